// File: rtl/sm_display_pkg.sv
// Shared definitions for the seven-segment display drivers: segment codes,
// the active-low hex decode and a width helper.
package sm_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Bits needed to index n items; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Active-low segment code, bit order g..a (bit 0 = segment a).
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t code;
        case (nib)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module sm_hex_to_seg
    import sm_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed hex seven-segment display driver with snapshot capture.
// Define SM_HEX_LZB_EN to enable leading-zero blanking.
module sm_hex_display
    import sm_display_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_SHIFT = 10
) (
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic                  update,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dpMask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frameDone
);

    localparam int unsigned IDXW = clog2(DIGITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    logic [SCAN_SHIFT-1:0] pre_q, pre_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_val_q, snap_val_d;
    logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]     snap_blank_q, snap_blank_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic [DIGITS-1:0]     cap_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg;

`ifdef SM_HEX_LZB_EN
    logic upper_zero;

    // Walk from the top digit down; a digit blanks while everything above it is zero.
    always_comb begin
        cap_blank  = '0;
        upper_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            upper_zero = upper_zero & (value[4*(DIGITS-1-k) +: 4] == 4'h0);
            cap_blank[DIGITS-1-k] = upper_zero;
        end
    end
`else
    always_comb begin
        cap_blank = '0;
    end
`endif

    assign cur_nib = snap_val_q[{idx_q, 2'b00} +: 4];

    sm_hex_to_seg u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        tick         = &pre_q;
        pre_d        = pre_q + SCAN_SHIFT'(1);
        idx_d        = idx_q;
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
        end

        if (update) begin
            snap_val_d   = value;
            snap_dp_d    = dpMask;
            snap_blank_d = cap_blank;
        end

        an_d = ~(DIGITS'(1) << idx_q);
        seg_d = snap_blank_q[idx_q] ? SEG_BLANK : dec_seg;
        dp_d = ~snap_dp_q[idx_q];

        // Dark slot while the digit index switches, to avoid ghosting.
        if (tick) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end

        frame_done_d = tick && (idx_q == LAST_IDX);
    end

    always_ff @(posedge clkIn) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign frameDone = frame_done_q;

endmodule
